// File: rtl/usb_hc_axil_regbank.sv
// rtl/usb_hc_axil_regbank.sv - parametrised AXI4-Lite register bank with RW/RO/W1C registers and irq
module usb_hc_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS = 16,
  parameter logic [63:0] RO_MASK = 64'h0,
  parameter logic [63:0] W1C_MASK = 64'h0,
  parameter logic [NUM_REGS*32-1:0] RESET_VAL = '0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          reg_q,
  output logic [NUM_REGS-1:0]             reg_wr_stb,
  input  logic [NUM_REGS*32-1:0]          hw_ro_in,
  input  logic [NUM_REGS*32-1:0]          hw_w1c_set,
  output logic                            irq
);
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_WAIT_W  = 2'd1;
  localparam logic [1:0] W_WAIT_AW = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;

  logic [1:0]          r_wstate;
  logic [1:0]          w_wstate_nxt;
  logic [IW-1:0]       r_awidx;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic [1:0]          r_bresp;
  logic [NUM_REGS-1:0] r_wr_stb;
  logic                r_ar_pend;
  logic [IW-1:0]       r_aridx;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic                r_irq;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic                w_commit;
  logic [IW-1:0]       w_cur_idx;
  logic [31:0]         w_cur_idx32;
  logic [31:0]         w_cur_data;
  logic [3:0]          w_cur_strb;
  logic [31:0]         w_bmask;
  logic                w_wr_ok;
  logic [NUM_REGS-1:0] w_wsel;
  logic [31:0]         w_ridx32;
  logic [31:0]         w_rdata;
  logic                w_w1c_any;
  logic                w_unused_ok;

  assign S_AXI_AWREADY = (r_wstate == W_IDLE) || (r_wstate == W_WAIT_AW);
  assign S_AXI_WREADY  = (r_wstate == W_IDLE) || (r_wstate == W_WAIT_W);
  assign S_AXI_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = !r_ar_pend && !r_rvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_wr_stb    = r_wr_stb;
  assign irq           = r_irq;

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // The transaction commits on the edge carrying whichever half arrives last.
  assign w_commit    = (w_aw_hs || r_wstate == W_WAIT_W) && (w_w_hs || r_wstate == W_WAIT_AW);
  assign w_cur_idx   = w_aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : r_awidx;
  assign w_cur_data  = w_w_hs ? S_AXI_WDATA : r_wdata;
  assign w_cur_strb  = w_w_hs ? S_AXI_WSTRB : r_wstrb;
  assign w_cur_idx32 = 32'(w_cur_idx);
  assign w_wr_ok     = w_cur_idx32 < 32'(NUM_REGS);
  assign w_bmask     = {{8{w_cur_strb[3]}}, {8{w_cur_strb[2]}}, {8{w_cur_strb[1]}}, {8{w_cur_strb[0]}}};

  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_commit && w_cur_idx32 == 32'(i)) w_wsel[i] = 1'b1;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_commit)     w_wstate_nxt = W_RESP;
        else if (w_aw_hs) w_wstate_nxt = W_WAIT_W;
        else if (w_w_hs)  w_wstate_nxt = W_WAIT_AW;
      end
      W_WAIT_W, W_WAIT_AW: begin
        if (w_commit) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_wstate <= W_IDLE;
      r_awidx  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= 2'b00;
      r_wr_stb <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wr_stb <= w_wsel;
      if (w_aw_hs) r_awidx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_ok ? 2'b00 : 2'b10;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_q[gi*32 +: 32] = hw_ro_in[gi*32 +: 32];
    end else begin : g_st
      logic [31:0] r_val;
      // Hardware set is OR-ed in after the software clear so a coincident set wins.
      always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN)
          r_val <= RESET_VAL[gi*32 +: 32];
        else if (W1C_MASK[gi])
          r_val <= (r_val & ~(w_wsel[gi] ? (w_cur_data & w_bmask) : 32'h0)) | hw_w1c_set[gi*32 +: 32];
        else if (w_wsel[gi])
          r_val <= (r_val & ~w_bmask) | (w_cur_data & w_bmask);
      end
      assign reg_q[gi*32 +: 32] = r_val;
    end
  end

  always_comb begin
    w_w1c_any = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (W1C_MASK[i]) w_w1c_any = w_w1c_any | (|reg_q[i*32 +: 32]);
    end
  end

  assign w_ridx32 = 32'(r_aridx);

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ridx32 == 32'(i)) w_rdata = reg_q[i*32 +: 32];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_ar_pend <= 1'b0;
      r_aridx   <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_irq     <= 1'b0;
    end else begin
      r_irq     <= w_w1c_any;
      r_ar_pend <= w_ar_hs;
      if (w_ar_hs) r_aridx <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (r_ar_pend) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= (w_ridx32 < 32'(NUM_REGS)) ? 2'b00 : 2'b10;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         hw_ro_in, hw_w1c_set};
endmodule

// File: doc/usb_hc_axil_regbank.md
Name: usb_hc_axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; next generation of the fixed four-register S00_AXI slave in the USB 1.1 host-controller IP.
- Register count, width, per-register access type (RW / RO / W1C) and reset values are all parameters.
- Independent AW/W acceptance and SLVERR on unmapped addresses.
- Sits between the AXI interconnect and the HC core: drives control registers, samples status, aggregates interrupt status into irq.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus and register width; 32 only in this generation.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^(C_S_AXI_ADDR_WIDTH-2) >= NUM_REGS.
NUM_REGS, 16, number of 32-bit registers, 1..64.
RO_MASK, 'h0, bit i=1 -> register i read-only, read value is hw_ro_in slice i.
W1C_MASK, 'h0, bit i=1 -> register i write-1-to-clear; must not overlap RO_MASK.
RESET_VAL, 0, NUM_REGS*32 flattened reset values for RW/W1C registers.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset; synchronous, active-low
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
reg_q  out  NUM_REGS*32  current register contents (RO slots = hw_ro_in)
reg_wr_stb  out  NUM_REGS  one-cycle pulse on the commit edge of a successful write to register i
hw_ro_in  in  NUM_REGS*32  status values for RO registers
hw_w1c_set  in  NUM_REGS*32  per-bit set pulses for W1C registers
irq  out  1  registered OR of all W1C register bits

Behaviour:
- Reset (S_AXI_ARESETN=0 at an edge): AWREADY/WREADY=1, BVALID=RVALID=0, ARREADY=1, BRESP/RRESP/RDATA=0, reg_wr_stb=0, RW/W1C registers=RESET_VAL, irq=0. Any in-flight transaction is dropped with no response.
- Write FSM:
  - W_IDLE: AWREADY=WREADY=1.
  - AW only -> W_WAIT_W, AWREADY=0.
  - W only -> W_WAIT_AW, WREADY=0.
  - Both in the same cycle, or the missing half arriving -> W_RESP.
- Commit happens on the edge entering W_RESP, i.e. one cycle after the last of AW/W handshakes.
  - Commit effects: register updated, reg_wr_stb pulses, BVALID=1.
  - W_RESP holds AWREADY=WREADY=0 until BVALID&&BREADY, then returns to W_IDLE.
- Decode: index = AWADDR[C_S_AXI_ADDR_WIDTH-1:2]; the low two address bits are ignored.
  - index >= NUM_REGS: BRESP=10, no update, no strobe.
- Write types:
  - RW: byte lane k is updated only when WSTRB[k]=1.
  - RO: no update, BRESP=00, strobe still pulses.
  - W1C: bit b is cleared where WDATA[b]=1 and its lane strobe is 1.
- hw_w1c_set sets W1C bits every cycle. A set and a clear of the same bit on the same edge: set wins.
- Read: an AR handshake on edge k gives RVALID=1 after edge k+1.
  - RDATA is the register value as it stood before edge k+1; a write committing on that same edge is not visible.
  - Out-of-range index: RDATA=0, RRESP=10.
  - ARREADY=0 while RVALID=1; RVALID clears on RREADY.
- Read and write paths are fully independent and may be active concurrently.
- irq updates one cycle after any W1C bit changes.

Test Plan:
- Write 0x00000001..0x00000004 to 0x0,0x4,0x8,0xC (AW and W together), read back -> equal data, all responses OKAY, one reg_wr_stb pulse per write, BVALID one cycle after handshake.
- AW at cycle 0, W at cycle 3 to 0x8, data 0xA5A5A5A5 -> commit and BVALID at cycle 4. Repeat with W first.
- Partial write: 0xFFFFFFFF then 0x12345678 with WSTRB=0101 to reg 1 -> readback 0xFF34FF78.
- Out-of-range: NUM_REGS=16, write to 0x40 (ADDR_W=7) -> BRESP=10, no strobe. Read of 0x40 -> RDATA=0, RRESP=10.
- W1C and RO (W1C_MASK bit 2, RO_MASK bit 3):
  - Pulse hw_w1c_set bit0 of reg 2 -> irq=1.
  - Write 0x1 to 0x8 while the set pulse repeats on the same edge -> bit stays 1, irq stays 1.
  - Write 0x1 again with no set pulse -> bit clears, irq=0 one cycle later.
  - Write to 0xC with hw_ro_in=0xDEADBEEF -> OKAY, readback 0xDEADBEEF.
- Deassert S_AXI_ARESETN during W_RESP with BREADY held 0 -> BVALID=0 next edge, registers back to RESET_VAL.
